// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce FSM, press pulse
// and auto-repeat pulse train per channel, all outputs registered.
module button_conditioner #(
   parameter int N_BTN         = 5,
   parameter int DB_CYCLES     = 1000000,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000,
   parameter int CNT_W         = 27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] db_level,
   output logic [N_BTN-1:0] scen,
   output logic [N_BTN-1:0] mcen
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD      = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RP      = CNT_W'(REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      state_t           state;
      state_t           state_n;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_n;
      logic [CNT_W-1:0] rcnt;
      logic [CNT_W-1:0] rcnt_n;
      logic             rep;
      logic             rep_n;
      logic             fresh;
      logic             fresh_n;
      logic             s;
      logic             rpt_hit;
      logic             db_q;
      logic             scen_q;
      logic             mcen_q;

      assign s = sync2[i];
      // rep selects the spacing: first gap is the delay, later gaps the period
      assign rpt_hit = (rcnt == (rep ? RP : RD));

      always_comb begin
         state_n = state;
         cnt_n   = cnt;
         rcnt_n  = rcnt;
         rep_n   = rep;
         fresh_n = 1'b0;
         unique case (state)
            IDLE: begin
               if (s) begin
                  state_n = PRESS_WAIT;
                  cnt_n   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state_n = IDLE;
               end else if (cnt == DB_LAST) begin
                  state_n = HELD;
                  rcnt_n  = '0;
                  rep_n   = 1'b0;
                  fresh_n = 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt_n = cnt + 1'b1;
               end
            end
            HELD: begin
               if (rpt_hit) begin
                  rcnt_n = CNT_ONE;
                  rep_n  = 1'b1;
               end else if (rcnt != CNT_MAX) begin
                  rcnt_n = rcnt + 1'b1;
               end
               if (!s) begin
                  state_n = RELEASE_WAIT;
                  cnt_n   = '0;
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state_n = HELD;
               end else if (cnt == DB_LAST) begin
                  state_n = IDLE;
               end else if (cnt != CNT_MAX) begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rcnt   <= '0;
            rep    <= 1'b0;
            fresh  <= 1'b0;
            db_q   <= 1'b0;
            scen_q <= 1'b0;
            mcen_q <= 1'b0;
         end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rcnt   <= rcnt_n;
            rep    <= rep_n;
            fresh  <= fresh_n;
            db_q   <= (state == HELD) || (state == RELEASE_WAIT);
            scen_q <= (state == HELD) && fresh;
            mcen_q <= (state == HELD) && (fresh || rpt_hit);
         end
      end

      assign db_level[i] = db_q;
      assign scen[i]     = scen_q;
      assign mcen[i]     = mcen_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table of press lengths plus
// hand-built bounce/reset sequences, checked cycle by cycle via a scoreboard.
module tb_button_conditioner;

   localparam int NB  = 5;
   localparam int DB  = 4;
   localparam int RD  = 8;
   localparam int RP  = 3;
   localparam int LAT = DB + 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_in;
   logic [NB-1:0] db_level;
   logic [NB-1:0] scen;
   logic [NB-1:0] mcen;

   button_conditioner #(
      .N_BTN(NB),
      .DB_CYCLES(DB),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP),
      .CNT_W(27)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_in(btn_in),
      .db_level(db_level),
      .scen(scen),
      .mcen(mcen)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic [NB-1:0] s;
      logic [NB-1:0] m;
      logic [NB-1:0] dm;
      logic [NB-1:0] dv;
   } ev_t;

   typedef struct {
      logic [NB-1:0] mask;
      int            hold;
      int            n_scen;
      int            n_mcen;
   } vec_t;

   ev_t           sb[$];
   vec_t          tbl[7];
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            scen_cnt = 0;
   int            mcen_cnt = 0;
   bit            mon_en = 1'b0;
   logic [NB-1:0] exp_db = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [NB-1:0] act,
                      input logic [NB-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected event at cycle c; events on the same cycle are merged.
   task automatic push_ev(input int c, input logic [NB-1:0] s,
                          input logic [NB-1:0] m, input logic [NB-1:0] dm,
                          input logic [NB-1:0] dv);
      ev_t e;
      int  idx;
      idx = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc == c) begin
            e    = sb[i];
            e.s  = e.s | s;
            e.m  = e.m | m;
            e.dv = (e.dv & ~dm) | (dv & dm);
            e.dm = e.dm | dm;
            sb[i] = e;
            return;
         end
         if (sb[i].cyc > c) begin
            idx = i;
            break;
         end
      end
      e.cyc = c;
      e.s   = s;
      e.m   = m;
      e.dm  = dm;
      e.dv  = dv;
      sb.insert(idx, e);
   endtask

   // Clean press: first high sample on cycle e0, h high samples.
   task automatic push_press(input int e0, input int h,
                             input logic [NB-1:0] mask);
      if (h < DB + 1) return;
      push_ev(e0 + LAT, mask, mask, mask, mask);
      for (int k = RD; k <= h - (DB + 1); k += RP)
         push_ev(e0 + LAT + k, '0, mask, '0, '0);
      push_ev(e0 + h + LAT, '0, '0, mask, '0);
   endtask

   always @(negedge clk) begin : mon
      logic [NB-1:0] es;
      logic [NB-1:0] em;
      ev_t           e;
      if (mon_en) begin
         es = '0;
         em = '0;
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL sb_stale cyc=%0d event_cyc=%0d", cyc, e.cyc);
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e      = sb.pop_front();
            es     = e.s;
            em     = e.m;
            exp_db = (exp_db & ~e.dm) | (e.dv & e.dm);
         end
         chk("scen", scen, es);
         chk("mcen", mcen, em);
         chk("db_level", db_level, exp_db);
         scen_cnt += $countones(scen);
         mcen_cnt += $countones(mcen);
      end
   end

   initial begin
      int e0;
      int er;
      tbl[0] = '{5'b00001, 20, 1, 4};
      tbl[1] = '{5'b01000, 30, 1, 7};
      tbl[2] = '{5'b11111,  6, 5, 5};
      tbl[3] = '{5'b00100,  4, 0, 0};
      tbl[4] = '{5'b10000,  5, 1, 1};
      tbl[5] = '{5'b00010, 13, 1, 2};
      tbl[6] = '{5'b00010, 12, 1, 1};

      rst    = 1'b1;
      btn_in = '0;
      step(1);
      mon_en = 1'b1;
      step(2);
      chk("rst_db", db_level, '0);
      chk("rst_scen", scen, '0);
      chk("rst_mcen", mcen, '0);
      rst = 1'b0;
      step(3);

      foreach (tbl[v]) begin
         e0 = cyc + 1;
         push_press(e0, tbl[v].hold, tbl[v].mask);
         scen_cnt = 0;
         mcen_cnt = 0;
         btn_in = tbl[v].mask;
         step(tbl[v].hold);
         btn_in = '0;
         step(20);
         chk_i($sformatf("vec%0d_scen_n", v), scen_cnt, tbl[v].n_scen);
         chk_i($sformatf("vec%0d_mcen_n", v), mcen_cnt, tbl[v].n_mcen);
      end

      // press bounce: 3-cycle glitch, 1 low, then a real 10-cycle press
      e0 = cyc + 1;
      push_press(e0 + 4, 10, 5'b00010);
      scen_cnt = 0;
      btn_in = 5'b00010;
      step(3);
      btn_in = '0;
      step(1);
      btn_in = 5'b00010;
      step(10);
      btn_in = '0;
      step(20);
      chk_i("press_bounce_scen_n", scen_cnt, 1);

      // release bounce: low 2, high 1, then low for good
      e0 = cyc + 1;
      push_ev(e0 + LAT, 5'b00100, 5'b00100, 5'b00100, 5'b00100);
      push_ev(e0 + 13 + LAT, '0, '0, 5'b00100, '0);
      scen_cnt = 0;
      btn_in = 5'b00100;
      step(10);
      btn_in = '0;
      step(2);
      btn_in = 5'b00100;
      step(1);
      btn_in = '0;
      step(25);
      chk_i("release_bounce_scen_n", scen_cnt, 1);

      // reset while held: fresh press measured from first non-reset edge
      e0 = cyc + 1;
      er = e0 + 12;
      push_ev(e0 + LAT, 5'b00001, 5'b00001, 5'b00001, 5'b00001);
      push_ev(er, '0, '0, 5'b00001, '0);
      push_press(er + 1, 15, 5'b00001);
      scen_cnt = 0;
      btn_in = 5'b00001;
      step(12);
      rst = 1'b1;
      step(1);
      chk("rst_mid_db", db_level, '0);
      rst = 1'b0;
      step(15);
      btn_in = '0;
      step(30);
      chk_i("rst_mid_scen_n", scen_cnt, 2);

      chk_i("sb_empty", sb.size(), 0);
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
